// File: rtl/pkt_if_pkg.sv
// Shared constants and types for the packet read master and its tag pipeline.
package pkt_if_pkg;

   localparam int ADDR_W = 16;

   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t ISSUE = 2'd1;
   localparam state_t DRAIN = 2'd2;
   localparam state_t DONE  = 2'd3;

   localparam logic [7:0] HDR_ADDR_HI  = 8'd0;
   localparam logic [7:0] HDR_ADDR_LO  = 8'd1;
   localparam logic [7:0] PAYLOAD_BASE = 8'd2;

   typedef struct packed {
      logic       vld;
      logic [7:0] addr;
   } tag_t;

endpackage

// File: rtl/pkt_tag_pipe.sv
// DEPTH-stage shift register of {valid, addr} tags that tracks reads in flight.
module pkt_tag_pipe
   import pkt_if_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t [DEPTH-1:0] stage;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/pkt_read_master.sv
// Packet read master: bursts addresses 0..PKT_LEN+1 to the slave, splits header/payload.
// Define PKT_READ_MASTER_CHKSUM_EN to add the pkt_sum payload checksum output.
module pkt_read_master
   import pkt_if_pkg::*;
#(
   parameter int PKT_LEN    = 16,
   parameter int RD_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              ram_rd_rq,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              new_msg,
   input  logic [7:0]        data_i,
   output logic [7:0]        out_data,
   output logic              out_valid,
   output logic              out_last,
   output logic [15:0]       hdr,
   output logic              busy,
   output logic              done,
   output logic              seq_err
`ifdef PKT_READ_MASTER_CHKSUM_EN
  ,output logic [7:0]        pkt_sum
`endif
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PKT_LEN + 1);
   localparam logic [7:0]        LAST_TAG  = 8'(PKT_LEN + 1);

   state_t     state, nxt;
   tag_t       tag_in, tag_out;
   logic [7:0] hdr_hi, hdr_lo;
   logic       seq_armed;
   logic       pay_hit;
   logic       fin;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = ISSUE;
         ISSUE:   if (rd_addr == LAST_ADDR) nxt = DRAIN;
         DRAIN:   if (out_last) nxt = DONE;
         default: nxt = IDLE;
      endcase
   end

   // rd_addr is zeroed on ISSUE entry, so 0 marks the first burst cycle
   always_comb begin
      ram_rd_rq = (state == ISSUE);
      new_msg   = (state == ISSUE) && (rd_addr == '0);
      busy      = (state != IDLE);
      done      = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         rd_addr <= '0;
      else if (state == IDLE && start)                 rd_addr <= '0;
      else if (state == ISSUE && rd_addr != LAST_ADDR) rd_addr <= rd_addr + 16'd1;
   end

   always_comb begin
      tag_in.vld  = (state == ISSUE);
      tag_in.addr = rd_addr[7:0];
   end

   pkt_tag_pipe #(.DEPTH(RD_LATENCY)) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // An exiting tag names the byte currently on data_i
   assign pay_hit = tag_out.vld && (tag_out.addr >= PAYLOAD_BASE);
   assign fin     = (state == DRAIN) && out_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hdr_hi    <= '0;
         hdr_lo    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         if (tag_out.vld && tag_out.addr == HDR_ADDR_HI) hdr_hi <= data_i;
         if (tag_out.vld && tag_out.addr == HDR_ADDR_LO) hdr_lo <= data_i;
         if (pay_hit) out_data <= data_i;
         out_valid <= pay_hit;
         out_last  <= pay_hit && (tag_out.addr == LAST_TAG);
      end
   end

   // First packet after reset only arms the check; 0xFFFF -> 0x0000 wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hdr       <= '0;
         seq_err   <= 1'b0;
         seq_armed <= 1'b0;
      end else if (fin) begin
         hdr       <= {hdr_hi, hdr_lo};
         seq_armed <= 1'b1;
         if (seq_armed && ({hdr_hi, hdr_lo} != hdr + 16'd1)) seq_err <= 1'b1;
      end
   end

`ifdef PKT_READ_MASTER_CHKSUM_EN
   logic [7:0] sum_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_acc <= '0;
         pkt_sum <= '0;
      end else begin
         if (state == IDLE && start) sum_acc <= '0;
         else if (pay_hit)           sum_acc <= sum_acc + data_i;
         if (fin) pkt_sum <= sum_acc;
      end
   end
`endif

endmodule
